// File: rtl/secded_pkg.sv
// Shared SECDED definitions: check-bit sizing, codeword positions and scrubber states.
package secded_pkg;

    // Smallest m with 2**m >= m + k + 1.
    function automatic int calculate_m(input int k);
        int m;
        m = 1;
        while ((1 << m) < (m + k + 1)) m++;
        return m;
    endfunction

    // Hamming position (1-based, bit 0 is the overall parity) of data bit i.
    // Data fills the non-power-of-two positions in ascending order.
    function automatic int data_pos(input int i);
        int pos;
        int seen;
        pos  = 0;
        seen = 0;
        for (int q = 3; q < 64; q++) begin
            if ((q & (q - 1)) != 0) begin
                if (seen == i && pos == 0) pos = q;
                seen++;
            end
        end
        return pos;
    endfunction

    // Position of the overall parity bit inside the stored codeword.
    localparam int OVERALL_POS = 0;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD_REQ  = 3'd1,
        S_RD_WAIT = 3'd2,
        S_CHECK   = 3'd3,
        S_WR_REQ  = 3'd4,
        S_GAP     = 3'd5
    } scrub_state_e;

endpackage

// File: rtl/secded_codec.sv
// Combinational SECDED codec: decode/correct a stored codeword and re-encode data.
module secded_codec
    import secded_pkg::*;
#(
    parameter  int K = 8,
    localparam int M = calculate_m(K),
    localparam int N = K + M + 1
) (
    input  logic [N-1:0] cw,
    output logic [K-1:0] dec_data,
    output logic         sec,
    output logic         ded,
    input  logic [K-1:0] enc_data,
    output logic [N-1:0] enc_cw
);

    logic [M-1:0] syn;
    logic [N-1:0] fixed_cw;

    // Syndrome + overall parity classify the word; a single flip is undone in place.
    always_comb begin
        syn      = '0;
        fixed_cw = cw;
        sec      = 1'b0;
        ded      = 1'b0;
        dec_data = '0;
        for (int q = 1; q < N; q++) begin
            if (cw[q]) syn = syn ^ M'(q);
        end
        if (^cw) begin
            // odd weight: single error at position syn (0 = overall parity bit)
            if (int'(syn) < N) begin
                sec = 1'b1;
                for (int q = 0; q < N; q++) begin
                    if (q == int'(syn)) fixed_cw[q] = ~cw[q];
                end
            end else begin
                ded = 1'b1;
            end
        end else if (syn != '0) begin
            ded = 1'b1;
        end
        for (int i = 0; i < K; i++) dec_data[i] = fixed_cw[data_pos(i)];
    end

    // Place data, derive each power-of-two check bit, then the overall parity.
    always_comb begin
        enc_cw = '0;
        for (int i = 0; i < K; i++) enc_cw[data_pos(i)] = enc_data[i];
        for (int j = 0; j < M; j++) begin
            for (int q = 1; q < N; q++) begin
                if (((q >> j) & 1) == 1 && q != (1 << j)) begin
                    enc_cw[1 << j] = enc_cw[1 << j] ^ enc_cw[q];
                end
            end
        end
        enc_cw[OVERALL_POS] = ^enc_cw[N-1:1];
    end

endmodule

// File: rtl/secded_scrub_ctrl.sv
// Background ECC scrubber: walks the memory, corrects single-bit errors by
// writeback and logs double-bit errors. Shares the port via req/gnt.
//
// state     | meaning
// ----------+--------------------------------------------------
// S_IDLE    | scrubbing disabled, pointer retained
// S_RD_REQ  | read request at ptr held until granted
// S_RD_WAIT | waiting for read data valid
// S_CHECK   | decode captured word, update counters/writeback
// S_WR_REQ  | corrected writeback held until granted
// S_GAP     | idle spacing, then advance pointer
module secded_scrub_ctrl
    import secded_pkg::*;
#(
    parameter  int K        = 8,
    parameter  int ADDR_W   = 4,
    parameter  int INTERVAL = 4,
    parameter  int CNT_W    = 8,
    localparam int M        = calculate_m(K),
    localparam int N        = K + M + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_enable,
    input  logic              i_clr,
    output logic              o_mem_req,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [N-1:0]      o_mem_wdata,
    input  logic              i_mem_gnt,
    input  logic              i_mem_rvalid,
    input  logic [N-1:0]      i_mem_rdata,
    output logic              o_busy,
    output logic              o_sweep_done,
    output logic [CNT_W-1:0]  o_sec_cnt,
    output logic [CNT_W-1:0]  o_ded_cnt,
    output logic              o_ded_flag,
    output logic [ADDR_W-1:0] o_ded_addr
);

    localparam int GAP_W = (INTERVAL > 0) ? $clog2(INTERVAL + 1) : 1;
    localparam logic [ADDR_W-1:0] PTR_LAST = '1;

    scrub_state_e      state;
    logic [ADDR_W-1:0] ptr;
    logic [N-1:0]      rdata_q;
    logic [GAP_W-1:0]  gap_cnt;
    logic [K-1:0]      dec_data;
    logic              dec_sec;
    logic              dec_ded;
    logic [N-1:0]      enc_cw;

    secded_codec #(.K(K)) u_codec (
        .cw       (rdata_q),
        .dec_data (dec_data),
        .sec      (dec_sec),
        .ded      (dec_ded),
        .enc_data (dec_data),
        .enc_cw   (enc_cw)
    );

    // Scrub sequencer with registered memory-port outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            ptr          <= '0;
            rdata_q      <= '0;
            gap_cnt      <= '0;
            o_mem_req    <= 1'b0;
            o_mem_we     <= 1'b0;
            o_mem_addr   <= '0;
            o_mem_wdata  <= '0;
            o_busy       <= 1'b0;
            o_sweep_done <= 1'b0;
        end else begin
            o_sweep_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (i_enable) begin
                        state      <= S_RD_REQ;
                        o_mem_req  <= 1'b1;
                        o_mem_we   <= 1'b0;
                        o_mem_addr <= ptr;
                        o_busy     <= 1'b1;
                    end
                end
                S_RD_REQ: begin
                    if (i_mem_gnt) begin
                        state     <= S_RD_WAIT;
                        o_mem_req <= 1'b0;
                    end
                end
                S_RD_WAIT: begin
                    if (i_mem_rvalid) begin
                        rdata_q <= i_mem_rdata;
                        state   <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (dec_sec) begin
                        o_mem_wdata <= enc_cw;
                        o_mem_req   <= 1'b1;
                        o_mem_we    <= 1'b1;
                        o_mem_addr  <= ptr;
                        state       <= S_WR_REQ;
                    end else begin
                        gap_cnt <= GAP_W'(INTERVAL);
                        state   <= S_GAP;
                    end
                end
                S_WR_REQ: begin
                    if (i_mem_gnt) begin
                        o_mem_req <= 1'b0;
                        o_mem_we  <= 1'b0;
                        gap_cnt   <= GAP_W'(INTERVAL);
                        state     <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (gap_cnt != '0) begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end else begin
                        ptr <= ptr + 1'b1;
                        if (ptr == PTR_LAST) o_sweep_done <= 1'b1;
                        if (i_enable) begin
                            state      <= S_RD_REQ;
                            o_mem_req  <= 1'b1;
                            o_mem_we   <= 1'b0;
                            o_mem_addr <= ptr + 1'b1;
                        end else begin
                            state  <= S_IDLE;
                            o_busy <= 1'b0;
                        end
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    o_mem_req <= 1'b0;
                    o_mem_we  <= 1'b0;
                    o_busy    <= 1'b0;
                end
            endcase
        end
    end

    // Error statistics; a clear beats a same-cycle increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_sec_cnt  <= '0;
            o_ded_cnt  <= '0;
            o_ded_flag <= 1'b0;
            o_ded_addr <= '0;
        end else if (i_clr) begin
            o_sec_cnt  <= '0;
            o_ded_cnt  <= '0;
            o_ded_flag <= 1'b0;
            o_ded_addr <= '0;
        end else if (state == S_CHECK) begin
            if (dec_sec && o_sec_cnt != '1) o_sec_cnt <= o_sec_cnt + 1'b1;
            if (dec_ded) begin
                if (o_ded_cnt != '1) o_ded_cnt <= o_ded_cnt + 1'b1;
                o_ded_flag <= 1'b1;
                o_ded_addr <= ptr;
            end
        end
    end

endmodule

// File: tb/tb_secded_scrub_ctrl.sv
// Bench for secded_scrub_ctrl: memory model with grant/latency control and a
// writeback scoreboard fed from the injected error pattern of each read.
module tb_secded_scrub_ctrl;
    import secded_pkg::*;

    localparam int K      = 8;
    localparam int ADDR_W = 4;
    localparam int CNT_W  = 8;
    localparam int M      = calculate_m(K);
    localparam int N      = K + M + 1;
    localparam int DEPTH  = 1 << ADDR_W;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [N-1:0]      cw;
    } wr_exp_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              i_enable = 1'b0;
    logic              i_clr = 1'b0;
    logic              o_mem_req;
    logic              o_mem_we;
    logic [ADDR_W-1:0] o_mem_addr;
    logic [N-1:0]      o_mem_wdata;
    logic              i_mem_gnt = 1'b1;
    logic              i_mem_rvalid = 1'b0;
    logic [N-1:0]      i_mem_rdata = '0;
    logic              o_busy;
    logic              o_sweep_done;
    logic [CNT_W-1:0]  o_sec_cnt;
    logic [CNT_W-1:0]  o_ded_cnt;
    logic              o_ded_flag;
    logic [ADDR_W-1:0] o_ded_addr;

    secded_scrub_ctrl #(.K(K), .ADDR_W(ADDR_W), .INTERVAL(4), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_enable     (i_enable),
        .i_clr        (i_clr),
        .o_mem_req    (o_mem_req),
        .o_mem_we     (o_mem_we),
        .o_mem_addr   (o_mem_addr),
        .o_mem_wdata  (o_mem_wdata),
        .i_mem_gnt    (i_mem_gnt),
        .i_mem_rvalid (i_mem_rvalid),
        .i_mem_rdata  (i_mem_rdata),
        .o_busy       (o_busy),
        .o_sweep_done (o_sweep_done),
        .o_sec_cnt    (o_sec_cnt),
        .o_ded_cnt    (o_ded_cnt),
        .o_ded_flag   (o_ded_flag),
        .o_ded_addr   (o_ded_addr)
    );

    initial forever #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [N-1:0]      clean [DEPTH];
    logic [N-1:0]      mem   [DEPTH];
    logic [N-1:0]      force_mask = '0;
    wr_exp_t           wr_q [$];
    int                rd_cnt = 0, wr_cnt = 0, sweep_cnt = 0;
    int                rd_lat = 1, rd_pend = 0;
    logic [N-1:0]      rd_data = '0;
    int                stall_rd = 0, stall_wr = 0;
    bit                snap_ok = 1'b0;
    logic              snap_we;
    logic [ADDR_W-1:0] snap_addr;
    logic [N-1:0]      snap_wdata;
    logic [ADDR_W-1:0] exp_rd_addr = '0, last_rd_addr = '0;
    int                sec_m = 0, ded_m = 0;
    logic              flag_m = 1'b0;
    logic [ADDR_W-1:0] ded_addr_m = '0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Independent Hamming(12,8)+parity encoder: data at 3,5,6,7,9,10,11,12.
    function automatic logic [N-1:0] tb_encode(input logic [K-1:0] d);
        int           dpos [8];
        logic [N-1:0] c;
        logic         p;
        dpos = '{3, 5, 6, 7, 9, 10, 11, 12};
        c = '0;
        for (int i = 0; i < 8; i++) c[dpos[i]] = d[i];
        for (int j = 0; j < 4; j++) begin
            p = 1'b0;
            for (int i = 0; i < 8; i++) if ((dpos[i] & (1 << j)) != 0) p = p ^ d[i];
            c[1 << j] = p;
        end
        c[0] = ^c;
        return c;
    endfunction

    function automatic int sat_inc(input int v);
        return (v >= (1 << CNT_W) - 1) ? v : v + 1;
    endfunction

    // Memory model: grant/stall control, read latency, scoreboard push/pop.
    initial begin : mem_model
        logic [ADDR_W-1:0] a;
        logic [N-1:0]      ret;
        int                nerr;
        wr_exp_t           e;
        forever begin
            @(negedge clk);
            i_mem_rvalid = 1'b0;
            if (rd_pend > 0) begin
                rd_pend--;
                if (rd_pend == 0) begin
                    i_mem_rvalid = 1'b1;
                    i_mem_rdata  = rd_data;
                end
            end
            if (o_sweep_done) sweep_cnt++;
            i_mem_gnt = 1'b1;
            if (rst_n) begin
                if (snap_ok && !o_mem_req) begin
                    check_val("stall_req", 32'(o_mem_req), 32'd1);
                    snap_ok = 1'b0;
                end
                if (o_mem_req && ((o_mem_we && stall_wr > 0) || (!o_mem_we && stall_rd > 0))) begin
                    i_mem_gnt = 1'b0;
                    if (!snap_ok) begin
                        snap_ok    = 1'b1;
                        snap_we    = o_mem_we;
                        snap_addr  = o_mem_addr;
                        snap_wdata = o_mem_wdata;
                    end else begin
                        check_val("stall_we", 32'(o_mem_we), 32'(snap_we));
                        check_val("stall_addr", 32'(o_mem_addr), 32'(snap_addr));
                        check_val("stall_wdata", 32'(o_mem_wdata), 32'(snap_wdata));
                    end
                    if (o_mem_we) stall_wr--; else stall_rd--;
                end else if (o_mem_req) begin
                    snap_ok = 1'b0;
                    a = o_mem_addr;
                    if (o_mem_we) begin
                        check_val("wr_expected", 32'(wr_q.size() > 0), 32'd1);
                        if (wr_q.size() > 0) begin
                            e = wr_q.pop_front();
                            check_val("wr_addr", 32'(a), 32'(e.addr));
                            check_val("wr_data", 32'(o_mem_wdata), 32'(e.cw));
                        end
                        mem[a] = o_mem_wdata;
                        wr_cnt++;
                    end else begin
                        check_val("rd_addr", 32'(a), 32'(exp_rd_addr));
                        ret  = mem[a] ^ force_mask;
                        nerr = $countones(ret ^ clean[a]);
                        if (nerr == 1) begin
                            e.addr = a;
                            e.cw   = clean[a];
                            wr_q.push_back(e);
                            sec_m = sat_inc(sec_m);
                        end else if (nerr == 2) begin
                            ded_m      = sat_inc(ded_m);
                            flag_m     = 1'b1;
                            ded_addr_m = a;
                        end
                        rd_data      = ret;
                        rd_pend      = rd_lat;
                        exp_rd_addr  = exp_rd_addr + 1'b1;
                        last_rd_addr = a;
                        rd_cnt++;
                    end
                end
            end
        end
    end

    task automatic wait_idle();
        int budget;
        budget = 300;
        @(negedge clk); #1;
        while (o_busy && budget > 0) begin
            @(negedge clk); #1;
            budget--;
        end
        check_val("idle", 32'(o_busy), 32'd0);
    endtask

    task automatic run_words(input int n, output logic [ADDR_W-1:0] first);
        int start, budget;
        bit got;
        start  = rd_cnt;
        got    = 1'b0;
        first  = '0;
        budget = n * 40 + 200;
        i_enable = 1'b1;
        while (rd_cnt < start + n && budget > 0) begin
            @(negedge clk); #1;
            budget--;
            if (!got && rd_cnt > start) begin
                got   = 1'b1;
                first = last_rd_addr;
            end
        end
        i_enable = 1'b0;
        check_val("run_reads", 32'(rd_cnt - start), 32'(n));
        wait_idle();
    endtask

    task automatic check_model(input string tag);
        check_val({tag, "_sec"}, 32'(o_sec_cnt), 32'(sec_m));
        check_val({tag, "_ded"}, 32'(o_ded_cnt), 32'(ded_m));
        check_val({tag, "_flag"}, 32'(o_ded_flag), 32'(flag_m));
        check_val({tag, "_daddr"}, 32'(o_ded_addr), 32'(ded_addr_m));
        check_val({tag, "_wrq"}, 32'(wr_q.size()), 32'd0);
    endtask

    task automatic check_reset(input string tag);
        check_val({tag, "_req"}, 32'(o_mem_req), 32'd0);
        check_val({tag, "_we"}, 32'(o_mem_we), 32'd0);
        check_val({tag, "_addr"}, 32'(o_mem_addr), 32'd0);
        check_val({tag, "_wdata"}, 32'(o_mem_wdata), 32'd0);
        check_val({tag, "_busy"}, 32'(o_busy), 32'd0);
        check_val({tag, "_sweep"}, 32'(o_sweep_done), 32'd0);
        check_val({tag, "_sec"}, 32'(o_sec_cnt), 32'd0);
        check_val({tag, "_ded"}, 32'(o_ded_cnt), 32'd0);
        check_val({tag, "_flag"}, 32'(o_ded_flag), 32'd0);
        check_val({tag, "_daddr"}, 32'(o_ded_addr), 32'd0);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [ADDR_W-1:0] first;
        int rd0, wr0, sw0, budget;

        for (int a = 0; a < DEPTH; a++) begin
            clean[a] = tb_encode(K'(a));
            mem[a]   = clean[a];
        end
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1 check_reset("rst0");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        #1 check_val("idle_no_enable", 32'(o_busy), 32'd0);

        // clean sweep
        rd0 = rd_cnt; wr0 = wr_cnt; sw0 = sweep_cnt;
        run_words(16, first);
        check_val("clean_first", 32'(first), 32'd0);
        check_val("clean_reads", 32'(rd_cnt - rd0), 32'd16);
        check_val("clean_writes", 32'(wr_cnt - wr0), 32'd0);
        check_val("clean_sweeps", 32'(sweep_cnt - sw0), 32'd1);
        check_model("clean");

        // single-bit error at addr 5, then a second sweep with nothing to fix
        mem[5] = mem[5] ^ 13'h0008;
        wr0 = wr_cnt;
        run_words(16, first);
        check_val("sec_writes", 32'(wr_cnt - wr0), 32'd1);
        check_val("sec_mem5", 32'(mem[5]), 32'(clean[5]));
        check_model("sec");
        wr0 = wr_cnt;
        run_words(16, first);
        check_val("sec2_writes", 32'(wr_cnt - wr0), 32'd0);

        // double-bit error at addr 9, then clear
        mem[9] = mem[9] ^ 13'h0084;
        wr0 = wr_cnt;
        run_words(16, first);
        check_val("ded_writes", 32'(wr_cnt - wr0), 32'd0);
        check_val("ded_addr9", 32'(o_ded_addr), 32'd9);
        check_model("ded");
        @(negedge clk);
        i_clr = 1'b1;
        @(negedge clk);
        i_clr = 1'b0;
        sec_m = 0; ded_m = 0; flag_m = 1'b0; ded_addr_m = '0;
        #1 check_model("clr");
        mem[9] = clean[9];

        // backpressure on the read of addr 0 and the writeback of addr 2
        mem[2]   = mem[2] ^ 13'h0400;
        stall_rd = 5;
        stall_wr = 5;
        wr0 = wr_cnt;
        run_words(16, first);
        check_val("bp_rd_stalled", 32'(stall_rd), 32'd0);
        check_val("bp_wr_stalled", 32'(stall_wr), 32'd0);
        check_val("bp_writes", 32'(wr_cnt - wr0), 32'd1);
        check_model("bp");

        // enable dropped while reading addr 7, resume at addr 8
        rd_lat = 3;
        run_words(8, first);
        check_val("drop_last", 32'(last_rd_addr), 32'd7);
        repeat (5) @(negedge clk);
        #1 check_val("drop_busy", 32'(o_busy), 32'd0);
        run_words(4, first);
        check_val("resume_addr", 32'(first), 32'd8);
        rd_lat = 1;

        // async reset while a writeback waits for grant
        mem[1]   = mem[1] ^ 13'h0040;
        stall_wr = 1000;
        i_enable = 1'b1;
        budget   = 400;
        while (!(o_mem_req && o_mem_we) && budget > 0) begin
            @(negedge clk); #1;
            budget--;
        end
        check_val("wr_req_reached", 32'(o_mem_req && o_mem_we), 32'd1);
        repeat (2) @(negedge clk);
        #3 rst_n = 1'b0;
        #1 check_reset("rst_wr");
        stall_wr = 0; stall_rd = 0; snap_ok = 1'b0; rd_pend = 0;
        wr_q.delete();
        sec_m = 0; ded_m = 0; flag_m = 1'b0; ded_addr_m = '0;
        exp_rd_addr = '0;
        mem[1]     = clean[1];
        force_mask = 13'h0008;
        @(negedge clk);
        rst_n = 1'b1;

        // saturation: every read carries a single, then a double error
        run_words(260, first);
        check_val("rst_first_addr", 32'(first), 32'd0);
        check_val("sec_sat", 32'(o_sec_cnt), 32'd255);
        check_model("sat_sec");
        force_mask = 13'h0084;
        run_words(260, first);
        check_val("ded_sat", 32'(o_ded_cnt), 32'd255);
        check_model("sat_ded");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/secded_scrub_ctrl.md
Name: secded_scrub_ctrl

Overview:
Background memory scrubber that sequences the SECDED Hamming datapath over an ECC-protected memory. It walks every address, reads the stored codeword, and decodes it through the SECDED codec. Single-bit errors are written back corrected and re-encoded. Double-bit errors are logged and never written. It shares the memory port with functional traffic through a req/gnt handshake, so it sits between the memory arbiter and the ECC RAM.

Parameters:
K, 8, data bits per word
M, calculate_m(K) (=4 for K=8), Hamming check bits: smallest m with 2**m >= m+K+1
N, K+M+1 (=13), stored codeword width including overall parity bit
ADDR_W, 4, memory address width; sweep covers 0..2**ADDR_W-1
INTERVAL, 4, idle cycles between consecutive word scrubs (0 allowed)
CNT_W, 8, width of saturating error counters

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
i_enable  in  1  level; 1 = scrubbing permitted
i_clr  in  1  pulse; clears counters, sticky flag and o_ded_addr
o_mem_req  out  1  memory access request
o_mem_we  out  1  1 = write, 0 = read; valid while o_mem_req=1
o_mem_addr  out  ADDR_W  access address
o_mem_wdata  out  N  corrected codeword for writeback
i_mem_gnt  in  1  arbiter grant; the access is accepted in the cycle req&gnt=1
i_mem_rvalid  in  1  read data valid, at least 1 cycle after the read grant
i_mem_rdata  in  N  read codeword
o_busy  out  1  FSM not in IDLE
o_sweep_done  out  1  1-cycle pulse after the last address of a sweep is processed
o_sec_cnt  out  CNT_W  corrected-error count, saturating
o_ded_cnt  out  CNT_W  uncorrectable-error count, saturating
o_ded_flag  out  1  sticky; set on any double-bit error
o_ded_addr  out  ADDR_W  address of the most recent double-bit error

Behaviour:
- Reset (async, rst_n=0): all outputs 0; address pointer 0; FSM=IDLE; interval counter 0.
- States: IDLE, RD_REQ, RD_WAIT, CHECK, WR_REQ, GAP.
- IDLE: when i_enable=1, go to RD_REQ next cycle.
- RD_REQ: req=1, we=0, addr=ptr. Req, we and addr are held stable until gnt. On req&gnt, go to RD_WAIT.
- RD_WAIT: capture i_mem_rdata on i_mem_rvalid into a register, then go to CHECK. rvalid is ignored in every other state.
- CHECK: decode the registered codeword (one cycle, registered result).
  - No error: go to GAP.
  - Single-bit error (data, check or overall-parity bit): sec_cnt +1 (saturating), load wdata with the corrected, re-encoded codeword, go to WR_REQ.
  - Double-bit error: ded_cnt +1 (saturating), ded_flag=1, ded_addr=ptr, no write, go to GAP.
- WR_REQ: req=1, we=1, addr=ptr, wdata stable until gnt. On req&gnt, go to GAP.
- GAP: wait INTERVAL cycles (0 means one pass-through cycle). Then increment ptr.
  - If ptr was 2**ADDR_W-1: wrap to 0 and pulse o_sweep_done in that cycle.
  - Next state: RD_REQ if i_enable=1, else IDLE.
- i_enable deasserted mid-word: the current word completes, including any pending writeback. The FSM then goes to IDLE at the GAP exit. ptr is retained, so scrubbing resumes at the next address.
- i_clr: takes effect in the cycle it is asserted and does not disturb the FSM. If an error increment coincides with i_clr, the clear wins.
- Counters hold at 2**CNT_W-1.
- Read-to-writeback window: functional writes are the arbiter's responsibility; the scrubber never holds the port between its read and write.

Decomposition:
- Shared package secded_pkg holds calculate_m, the N/M derivation and the syndrome-position constants. The testbench and codec use it.
- One sub-module, secded_codec: purely combinational. Decodes N bits into corrected data, sec and ded flags, and also re-encodes K data bits into N.
- The FSM, counters and registers live in secded_scrub_ctrl.

Test Plan:
- Clean sweep: preload valid codewords for data 0..15, gnt always 1 → 16 reads, 0 writes, one o_sweep_done pulse, sec_cnt=0, ded_cnt=0.
- Single error: flip bit 3 of the word at addr 5 → exactly one write, at addr 5, with the original encoding of data 5; sec_cnt=1; a second sweep produces no write.
- Double error: flip bits 2 and 7 at addr 9 → no write; ded_cnt=1, ded_flag=1, ded_addr=9; i_clr → all three back to 0.
- Backpressure: gnt held low for 5 cycles on both a read and a write → req, we, addr and wdata stable throughout; the access completes exactly once.
- Enable drop: deassert i_enable during RD_WAIT at addr 7 → addr 7 completes, FSM reaches IDLE, busy=0; re-enable → next read is addr 8.
- Async reset: rst_n low during WR_REQ → outputs 0 immediately; after release with i_enable=1, first read is addr 0. Also preset counters to 255 plus one more error → counter stays 255.
